// File: rtl/fetch_redirect_unit_pkg.sv
// fetch_pkg: shared types and helpers for the fetch/redirect front end.
//   fetch_state_t     - RUN / HALTED control state
//   NOP_INSTR         - canonical RISC-V NOP (addi x0,x0,0)
//   is_legal_target() - word-aligned and representable in a pc_w-bit PC
package fetch_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // A target is legal when its low two bits are clear and no bit at or
    // above pc_w is set (otherwise it would silently alias in the PC).
    function automatic logic is_legal_target(input logic [31:0] target,
                                             input int unsigned pc_w);
        logic hi_clear;
        hi_clear = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= int'(pc_w) && target[i]) hi_clear = 1'b0;
        end
        return hi_clear && (target[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// fetch_redirect_unit_if: fetch-side bus between the pipeline and the fetch
// unit.
//   master (pipeline/imem side): drives stall, PcSel, BrPC, instr_in;
//                                observes imem_addr, IF/ID and flush_idex.
//   slave  (fetch unit):         the mirror image.
interface fetch_redirect_unit_if #(
    parameter int PC_W = 9
);
    logic            stall;
    logic            PcSel;
    logic [31:0]     BrPC;
    logic [31:0]     instr_in;
    logic [PC_W-1:0] imem_addr;
    logic [PC_W-1:0] ifid_pc;
    logic [31:0]     ifid_instr;
    logic            ifid_valid;
    logic            flush_idex;

    modport master (
        output stall, PcSel, BrPC, instr_in,
        input  imem_addr, ifid_pc, ifid_instr, ifid_valid, flush_idex
    );

    modport slave (
        input  stall, PcSel, BrPC, instr_in,
        output imem_addr, ifid_pc, ifid_instr, ifid_valid, flush_idex
    );
endinterface

// File: rtl/fetch_redirect_unit_ifid.sv
// ifid_reg: IF/ID pipeline register.
//   clk, reset     - clock, synchronous active-high reset
//   load           - capture pc_in/instr_in and mark valid
//   squash         - drop the held instruction (valid=0, instr=NOP)
//   pc_in,instr_in - fetched PC and instruction word
//   pc,instr,valid - register contents
// With neither load nor squash the register holds. squash wins over load.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int PC_W = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            squash,
    input  logic [PC_W-1:0] pc_in,
    input  logic [31:0]     instr_in,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     instr,
    output logic            valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (squash) begin
            // pc is left alone; only the valid bit matters downstream
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            pc    <= pc_in;
            instr <= instr_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: fetch stage with branch/jump redirect handling.
//   clk, reset      - clock, synchronous active-high reset
//   bus (slave)     - stall/PcSel/BrPC/instr_in in; imem_addr, IF/ID,
//                     flush_idex out
//   halted          - unit stopped after an illegal redirect target
//   target_err      - sticky illegal-target flag
//   redirect_count  - accepted redirects, saturating at all-ones
// Priority in RUN: illegal redirect > legal redirect > stall > advance.
// HALTED ignores everything but reset.
module fetch_redirect_unit
    import fetch_pkg::*;
#(
    parameter int PC_W     = 9,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_redirect_unit_if.slave  bus,
    output logic                  halted,
    output logic                  target_err,
    output logic [CNT_W-1:0]      redirect_count
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;

    logic redirect;
    logic legal;
    logic ifid_load;
    logic ifid_squash;

    assign redirect = (state == RUN) && bus.PcSel;
    assign legal    = is_legal_target(bus.BrPC, PC_W);

    // Any redirect in RUN, legal or not, kills the wrong-path fetch.
    assign ifid_squash = redirect;
    assign ifid_load   = (state == RUN) && !bus.PcSel && !bus.stall;

    assign bus.imem_addr  = pc;
    assign bus.flush_idex = redirect;
    assign halted         = (state == HALTED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            pc             <= PC_W'(RESET_PC);
            target_err     <= 1'b0;
            redirect_count <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.PcSel) begin
                        if (!legal) begin
                            state      <= HALTED;
                            target_err <= 1'b1;
                        end else begin
                            pc <= bus.BrPC[PC_W-1:0];
                            if (redirect_count != '1)
                                redirect_count <= redirect_count + 1'b1;
                        end
                    end else if (!bus.stall) begin
                        pc <= pc + PC_W'(4);
                    end
                end
                HALTED: ;
                default: state <= HALTED;
            endcase
        end
    end

    ifid_reg #(.PC_W(PC_W)) u_ifid (
        .clk      (clk),
        .reset    (reset),
        .load     (ifid_load),
        .squash   (ifid_squash),
        .pc_in    (pc),
        .instr_in (bus.instr_in),
        .pc       (bus.ifid_pc),
        .instr    (bus.ifid_instr),
        .valid    (bus.ifid_valid)
    );

endmodule
